// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch front end.
package if_pkg;

  localparam int ADDR_W = 17;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h00000013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: circular buffer of fetched {pc, inst} entries with a single-cycle flush.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale words are never seen.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC register, RUN/FAULT control and decode-side handshake.
module inst_fetch_unit
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 17'h00000,
  parameter int                DEPTH    = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] pc;
  logic              aligned;
  logic              fetch;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     fill;
  fetch_entry_t      head;

  assign aligned   = (redirect_pc[1:0] == 2'b00);
  assign imem_addr = pc;
  assign pop       = if_valid & if_ready;
  assign fetch     = (state == RUN) & fetch_en & ~redirect_valid & (~full | pop);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fetch),
    .pop     (pop),
    .flush   (redirect_valid),
    .din     ('{pc: pc, inst: imem_inst}),
    .dout    (head),
    .count   (fill),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= RUN;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (redirect_valid) next_state = aligned ? RUN : FAULT;
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    fault    = (state == FAULT);
    if_valid = 1'b0;
    if_inst  = '0;
    if_pc    = '0;
    if (!empty) begin
      if_inst = head.inst;
      if_pc   = head.pc;
    end
    // A redirect kills the head in its own cycle so decode never consumes a wrong-path word.
    if (state == RUN && fill != '0 && !redirect_valid) if_valid = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      if (aligned) pc       <= redirect_pc;
      else         fault_pc <= redirect_pc;
    end else if (fetch) begin
      pc <= pc + ADDR_W'(4);
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: streaming, back-pressure, redirect, fault, PC wrap, reset.
module tb_inst_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n, reset_n_w;
  logic        fetch_en, redirect_valid, if_ready;
  logic [16:0] redirect_pc;
  logic [16:0] imem_addr, if_pc, fault_pc;
  logic [31:0] imem_inst, if_inst;
  logic        if_valid, fault;

  logic [16:0] imem_addr_w, if_pc_w, fault_pc_w;
  logic [31:0] imem_inst_w, if_inst_w;
  logic        if_valid_w, fault_w;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [16:0] addr);
    case (addr)
      17'h00000: mem_word = 32'h00200113;
      17'h00004: mem_word = 32'h00000093;
      default:   mem_word = 32'hC0DE0000 ^ {15'd0, addr};
    endcase
  endfunction

  assign imem_inst   = mem_word(imem_addr);
  assign imem_inst_w = mem_word(imem_addr_w);

  inst_fetch_unit dut (
    .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .fault(fault), .fault_pc(fault_pc)
  );

  inst_fetch_unit #(.RESET_PC(17'h1FFF8)) dut_w (
    .clock(clock), .reset_n(reset_n_w), .fetch_en(1'b1),
    .redirect_valid(1'b0), .redirect_pc(17'h00000),
    .imem_addr(imem_addr_w), .imem_inst(imem_inst_w),
    .if_valid(if_valid_w), .if_ready(1'b1), .if_inst(if_inst_w), .if_pc(if_pc_w),
    .fault(fault_w), .fault_pc(fault_pc_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    reset_n_w      = 1'b0;
    fetch_en       = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();

    // Reset state
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_inst", if_inst, 32'd0);
    check("rst_pc", 32'(if_pc), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_pc", 32'(fault_pc), 32'd0);

    // Streaming, one word per cycle
    reset_n  = 1'b1;
    fetch_en = 1'b1;
    if_ready = 1'b1;
    tick();
    check("s0_valid", 32'(if_valid), 32'd1);
    check("s0_pc", 32'(if_pc), 32'h0);
    check("s0_inst", if_inst, 32'h00200113);
    check("s0_addr", 32'(imem_addr), 32'h4);
    tick();
    check("s1_valid", 32'(if_valid), 32'd1);
    check("s1_pc", 32'(if_pc), 32'h4);
    check("s1_inst", if_inst, 32'h00000093);
    tick();
    check("s2_pc", 32'(if_pc), 32'h8);
    check("s2_inst", if_inst, mem_word(17'h8));

    // Back-pressure fills the FIFO, then drains without gaps
    if_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    check("bp_addr", 32'(imem_addr), 32'h8);
    check("bp_valid", 32'(if_valid), 32'd1);
    check("bp_pc", 32'(if_pc), 32'h0);
    check("bp_inst", if_inst, 32'h00200113);
    tick();
    check("bp_hold_pc", 32'(if_pc), 32'h0);
    check("bp_hold_addr", 32'(imem_addr), 32'h8);
    if_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), 32'(if_valid), 32'd1);
      check($sformatf("drain%0d_pc", i), 32'(if_pc), 32'(i * 4));
      check($sformatf("drain%0d_inst", i), if_inst, mem_word(17'(i * 4)));
      tick();
    end

    // Redirect with two entries buffered
    if_ready = 1'b0;
    do_reset();
    tick();
    tick();
    check("rd_pre_pc", 32'(if_pc), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 17'h00100;
    if_ready       = 1'b1;
    #1;
    check("rd_masked", 32'(if_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rd_addr", 32'(imem_addr), 32'h100);
    check("rd_empty", 32'(if_valid), 32'd0);
    tick();
    check("rd_valid", 32'(if_valid), 32'd1);
    check("rd_pc", 32'(if_pc), 32'h100);
    check("rd_inst", if_inst, mem_word(17'h100));

    // Misaligned redirect faults; pc currently 0x104
    redirect_valid = 1'b1;
    redirect_pc    = 17'h00102;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check("flt_fault", 32'(fault), 32'd1);
    check("flt_fault_pc", 32'(fault_pc), 32'h102);
    check("flt_valid", 32'(if_valid), 32'd0);
    check("flt_addr", 32'(imem_addr), 32'h104);
    redirect_valid = 1'b1;
    redirect_pc    = 17'h00200;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("flt_clear", 32'(fault), 32'd0);
    check("flt_resume_addr", 32'(imem_addr), 32'h200);
    tick();
    check("flt_resume_valid", 32'(if_valid), 32'd1);
    check("flt_resume_pc", 32'(if_pc), 32'h200);

    // PC wrap on the second instance
    reset_n_w = 1'b1;
    tick();
    check("wrap0", 32'(if_pc_w), 32'h1FFF8);
    tick();
    check("wrap1", 32'(if_pc_w), 32'h1FFFC);
    tick();
    check("wrap2", 32'(if_pc_w), 32'h00000);
    check("wrap2_inst", if_inst_w, 32'h00200113);
    tick();
    check("wrap3", 32'(if_pc_w), 32'h00004);

    // Push and pop while full keep the count at DEPTH
    if_ready = 1'b0;
    fetch_en = 1'b1;
    do_reset();
    tick();
    tick();
    if_ready = 1'b1;
    tick();
    check("full_pp_pc", 32'(if_pc), 32'h4);
    check("full_pp_addr", 32'(imem_addr), 32'hC);
    fetch_en = 1'b0;
    tick();
    check("full_d1_valid", 32'(if_valid), 32'd1);
    check("full_d1_pc", 32'(if_pc), 32'h8);
    tick();
    check("full_d2_empty", 32'(if_valid), 32'd0);
    check("full_hold_addr", 32'(imem_addr), 32'hC);

    // Reset beats a simultaneous misaligned redirect mid-stream
    fetch_en = 1'b1;
    tick();
    tick();
    reset_n        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 17'h00102;
    tick();
    reset_n        = 1'b1;
    redirect_valid = 1'b0;
    fetch_en       = 1'b0;
    #1;
    check("mid_rst_addr", 32'(imem_addr), 32'h0);
    check("mid_rst_valid", 32'(if_valid), 32'd0);
    check("mid_rst_fault", 32'(fault), 32'd0);
    check("mid_rst_fault_pc", 32'(fault_pc), 32'd0);
    check("mid_rst_pc", 32'(if_pc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
